// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/interlock controller.
// The datapath is the master: it drives stage info in and receives enables, flushes and statistics.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_is_branch;
    logic             branch_taken;
    logic             id_halt;
    logic             resume;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             mem_memread;
    logic [4:0]       mem_rd;
    logic             ex_mdu_start;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, branch_taken,
               id_halt, resume, ex_memread, ex_rd, mem_memread, mem_rd, ex_mdu_start,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, branch_taken,
               id_halt, resume, ex_memread, ex_rd, mem_memread, mem_rd, ex_mdu_start,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline interlock (load-use, branch-on-load, MDU freeze, halt) with stall/flush stats.
// Latency: enables/flushes are combinational same-cycle; state and counters update on the edge.
// Backpressure: stalls hold PC and IF/ID; MDU freezes through EX; HALT drains until resume.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);
    localparam int             MW       = 4;
    localparam logic [MW-1:0]  MDU_LOAD = MW'(MDU_LAT - 2);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MDU  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [MW-1:0]    mdu_cnt, mdu_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic rs_ex, rt_ex, rs_mem, rt_mem, lu, bl;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, halted;
    logic stall_inc, flush_inc;

    // r0 is hardwired zero, so it never creates a dependence.
    assign rs_ex  = bus.id_use_rs && (bus.id_rs == bus.ex_rd)  && (bus.ex_rd  != 5'd0);
    assign rt_ex  = bus.id_use_rt && (bus.id_rt == bus.ex_rd)  && (bus.ex_rd  != 5'd0);
    assign rs_mem = bus.id_use_rs && (bus.id_rs == bus.mem_rd) && (bus.mem_rd != 5'd0);
    assign rt_mem = bus.id_use_rt && (bus.id_rt == bus.mem_rd) && (bus.mem_rd != 5'd0);
    assign lu     = bus.ex_memread && (rs_ex || rt_ex);
    assign bl     = bus.id_is_branch && bus.mem_memread && (rs_mem || rt_mem);

    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_mdu_start) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    mdu_cnt_nxt = MDU_LOAD;
                    state_nxt   = (MDU_LAT > 2) ? MDU : RUN;
                end else if (lu || bl) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.id_halt) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    state_nxt  = HALT;
                end else if (bus.branch_taken) begin
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end
            end
            MDU: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                // mdu_cnt holds the frozen cycles still owed, this one included.
                mdu_cnt_nxt = mdu_cnt - 1'b1;
                if (mdu_cnt <= 4'd1) begin
                    mdu_cnt_nxt = '0;
                    state_nxt   = RUN;
                end
            end
            HALT: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                halted     = 1'b1;
                if (bus.resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign stall_inc = !pc_en && (state != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mdu_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en       = rst_n & pc_en;
    assign bus.ifid_en     = rst_n & ifid_en;
    assign bus.ifid_flush  = rst_n & ifid_flush;
    assign bus.idex_en     = rst_n & idex_en;
    assign bus.idex_flush  = rst_n & idex_flush;
    assign bus.exmem_flush = rst_n & exmem_flush;
    assign bus.halted      = rst_n & halted;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus random traffic,
// all checked every negedge against a freeze-count/halt-flag model of the interlock rules.
module tb_hazard_ctrl;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bi ();

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: frozen cycles still owed after an MDU start, a halted flag, and plain int counters.
    int m_freeze = 0;
    bit m_halt   = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    always @(negedge clk) begin
        int  e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exfl, e_halt;
        bit  stall_now, flush_now, dep_ex, dep_mem;
        e_pc = 1; e_ifen = 1; e_iffl = 0; e_idexen = 1; e_idexfl = 0; e_exfl = 0; e_halt = 0;
        stall_now = 0;
        flush_now = 0;
        if (!rst_n) begin
            m_freeze = 0; m_halt = 0; m_stall = 0; m_flush = 0;
            e_pc = 0; e_ifen = 0; e_idexen = 0;
        end else if (m_freeze > 0) begin
            e_pc = 0; e_ifen = 0; e_idexen = 0; e_exfl = 1;
            stall_now = 1;
        end else if (m_halt) begin
            e_pc = 0; e_ifen = 0; e_idexfl = 1; e_halt = 1;
        end else begin
            dep_ex  = (bi.id_use_rs && bi.id_rs == bi.ex_rd && bi.ex_rd != 0) ||
                      (bi.id_use_rt && bi.id_rt == bi.ex_rd && bi.ex_rd != 0);
            dep_mem = (bi.id_use_rs && bi.id_rs == bi.mem_rd && bi.mem_rd != 0) ||
                      (bi.id_use_rt && bi.id_rt == bi.mem_rd && bi.mem_rd != 0);
            if (bi.ex_mdu_start) begin
                e_pc = 0; e_ifen = 0; e_idexen = 0; e_exfl = 1;
                stall_now = 1;
            end else if ((bi.ex_memread && dep_ex) || (bi.id_is_branch && bi.mem_memread && dep_mem)) begin
                e_pc = 0; e_ifen = 0; e_idexfl = 1;
                stall_now = 1;
            end else if (bi.id_halt) begin
                e_pc = 0; e_ifen = 0; e_idexfl = 1;
                stall_now = 1;
            end else if (bi.branch_taken) begin
                e_iffl = 1;
                flush_now = 1;
            end
        end
        chk("pc_en",       int'(bi.pc_en),       e_pc);
        chk("ifid_en",     int'(bi.ifid_en),     e_ifen);
        chk("ifid_flush",  int'(bi.ifid_flush),  e_iffl);
        chk("idex_en",     int'(bi.idex_en),     e_idexen);
        chk("idex_flush",  int'(bi.idex_flush),  e_idexfl);
        chk("exmem_flush", int'(bi.exmem_flush), e_exfl);
        chk("halted",      int'(bi.halted),      e_halt);
        chk("stall_cnt",   int'(bi.stall_cnt),   m_stall);
        chk("flush_cnt",   int'(bi.flush_cnt),   m_flush);
        if (rst_n) begin
            // Advance the model to what the next rising edge must produce.
            if (m_freeze > 0) begin
                m_freeze--;
            end else if (m_halt) begin
                if (bi.resume) m_halt = 0;
            end else if (bi.ex_mdu_start) begin
                m_freeze = MDU_LAT - 2;
            end else if (e_idexfl == 1 && e_idexen == 1 && bi.id_halt &&
                         !((bi.ex_memread && dep_ex) || (bi.id_is_branch && bi.mem_memread && dep_mem))) begin
                m_halt = 1;
            end
            if (stall_now) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (flush_now) m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
        end
    end

    task automatic idle();
        bi.id_rs = 0; bi.id_rt = 0; bi.id_use_rs = 0; bi.id_use_rt = 0;
        bi.id_is_branch = 0; bi.branch_taken = 0; bi.id_halt = 0; bi.resume = 0;
        bi.ex_memread = 0; bi.ex_rd = 0; bi.mem_memread = 0; bi.mem_rd = 0;
        bi.ex_mdu_start = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lu();
        bi.ex_memread = 1; bi.ex_rd = 5; bi.id_rs = 5; bi.id_use_rs = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step(2);
        chk("rst_pc_en",   int'(bi.pc_en),   0);
        chk("rst_idex_en", int'(bi.idex_en), 0);
        chk("rst_stall",   int'(bi.stall_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("run_pc_en", int'(bi.pc_en), 1);

        // Load-use, then the same pattern on r0.
        set_lu();
        #1;
        chk("lu_pc_en",      int'(bi.pc_en),      0);
        chk("lu_ifid_en",    int'(bi.ifid_en),    0);
        chk("lu_idex_flush", int'(bi.idex_flush), 1);
        step(1);
        idle();
        step(1);
        chk("lu_stall_cnt", int'(bi.stall_cnt), 1);
        bi.ex_memread = 1; bi.id_use_rs = 1;
        #1;
        chk("r0_pc_en", int'(bi.pc_en), 1);
        step(1);
        idle();

        // Branch on r3 behind a load of r3: lu then bl, then taken.
        bi.id_is_branch = 1; bi.id_rs = 3; bi.id_use_rs = 1; bi.ex_memread = 1; bi.ex_rd = 3;
        #1;
        chk("bl1_pc_en", int'(bi.pc_en), 0);
        step(1);
        bi.ex_memread = 0; bi.ex_rd = 0; bi.mem_memread = 1; bi.mem_rd = 3;
        #1;
        chk("bl2_pc_en", int'(bi.pc_en), 0);
        step(1);
        bi.mem_memread = 0; bi.branch_taken = 1;
        #1;
        chk("br_ifid_flush", int'(bi.ifid_flush), 1);
        chk("br_pc_en",      int'(bi.pc_en),      1);
        step(1);
        idle();
        #1;
        chk("br_stall_cnt", int'(bi.stall_cnt), 3);
        chk("br_flush_cnt", int'(bi.flush_cnt), 1);

        // MDU start with a coincident load-use, which must be ignored.
        bi.ex_mdu_start = 1;
        set_lu();
        #1;
        chk("mdu0_exmem_flush", int'(bi.exmem_flush), 1);
        chk("mdu0_idex_flush",  int'(bi.idex_flush),  0);
        chk("mdu0_idex_en",     int'(bi.idex_en),     0);
        step(1);
        idle();
        #1;
        chk("mdu1_pc_en", int'(bi.pc_en), 0);
        step(1);
        chk("mdu2_pc_en", int'(bi.pc_en), 0);
        step(1);
        chk("mdu_done_pc_en",  int'(bi.pc_en),       1);
        chk("mdu_done_exmem",  int'(bi.exmem_flush), 0);
        chk("mdu_stall_cnt",   int'(bi.stall_cnt),   6);

        // Halt for ten cycles, then resume.
        bi.id_halt = 1;
        #1;
        chk("halt0_pc_en",  int'(bi.pc_en),  0);
        chk("halt0_halted", int'(bi.halted), 0);
        step(1);
        idle();
        #1;
        chk("halt_halted", int'(bi.halted), 1);
        chk("halt_stall0", int'(bi.stall_cnt), 7);
        step(10);
        chk("halt_pc_en",  int'(bi.pc_en),     0);
        chk("halt_stall",  int'(bi.stall_cnt), 7);
        bi.resume = 1;
        #1;
        chk("resume0_halted", int'(bi.halted), 1);
        step(1);
        bi.resume = 0;
        #1;
        chk("resume_halted", int'(bi.halted), 0);
        chk("resume_pc_en",  int'(bi.pc_en),  1);

        // Twenty load-use stalls saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            set_lu();
            step(1);
            idle();
            step(1);
        end
        chk("sat_stall_cnt", int'(bi.stall_cnt), 15);

        // Reset in the middle of an MDU freeze.
        bi.ex_mdu_start = 1;
        step(1);
        idle();
        #1;
        chk("mrst_in_mdu", int'(bi.exmem_flush), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_pc_en",   int'(bi.pc_en),       0);
        chk("mrst_idex_en", int'(bi.idex_en),     0);
        chk("mrst_exmem",   int'(bi.exmem_flush), 0);
        chk("mrst_stall",   int'(bi.stall_cnt),   0);
        chk("mrst_flush",   int'(bi.flush_cnt),   0);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("mrst_run_pc_en", int'(bi.pc_en),       1);
        chk("mrst_run_exmem", int'(bi.exmem_flush), 0);

        // Random traffic on a small register pool so dependences are frequent.
        for (int i = 0; i < 3000; i++) begin
            bi.id_rs        = 5'($urandom_range(0, 3));
            bi.id_rt        = 5'($urandom_range(0, 3));
            bi.id_use_rs    = 1'($urandom_range(0, 1));
            bi.id_use_rt    = 1'($urandom_range(0, 1));
            bi.id_is_branch = 1'($urandom_range(0, 2) == 0);
            bi.branch_taken = 1'($urandom_range(0, 2) == 0);
            bi.id_halt      = 1'($urandom_range(0, 25) == 0);
            bi.resume       = 1'($urandom_range(0, 5) == 0);
            bi.ex_memread   = 1'($urandom_range(0, 2) == 0);
            bi.ex_rd        = 5'($urandom_range(0, 3));
            bi.mem_memread  = 1'($urandom_range(0, 2) == 0);
            bi.mem_rd       = 5'($urandom_range(0, 3));
            bi.ex_mdu_start = 1'($urandom_range(0, 15) == 0);
            rst_n           = ($urandom_range(0, 400) != 0);
            step(1);
        end
        rst_n = 1'b1;
        idle();
        step(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
